// File: rtl/fixed_pkg.sv
// Shared definitions for the unsigned 8.8 fixed-point datapath blocks.
// Provides the fixed-point format widths, the saturation ceiling and the
// state encoding used by the sequential dot-product accumulator.
package fixed_pkg;

    localparam int unsigned FIXED_W = 16;
    localparam int unsigned FRAC_W  = 8;
    localparam int unsigned INT_W   = 8;

    localparam logic [FIXED_W-1:0] FIXED_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } dot_state_e;

endpackage

// File: rtl/fixed_mul_trunc.sv
// Combinational unsigned 8.8 x 8.8 multiplier with truncation to 8.8.
// The fractional bits below the result LSB are dropped (no rounding) and any
// non-zero integer bits above the 8.8 range are reported as overflow.
//
// Ports:
//   a    : multiplicand, unsigned 8.8
//   b    : multiplier, unsigned 8.8
//   prod : truncated product, unsigned 8.8 (low 16 bits of the in-range field)
//   ovf  : product exceeded the 8.8 range
module fixed_mul_trunc
    import fixed_pkg::*;
(
    input  logic [FIXED_W-1:0] a,
    input  logic [FIXED_W-1:0] b,
    output logic [FIXED_W-1:0] prod,
    output logic               ovf
);

    logic [2*FIXED_W-1:0] raw;

    assign raw = a * b;

    // Shifting keeps every bit of raw in use while selecting the 8.8 window.
    assign prod = FIXED_W'(raw >> FRAC_W);
    assign ovf  = (raw >> (FIXED_W + FRAC_W)) != '0;

endmodule

// File: rtl/fixed_dot_acc.sv
// Sequential dot-product stage for unsigned 8.8 operands.
// Accepts LEN operand pairs over a valid/ready handshake, multiplies each pair
// (truncating to 8.8), accumulates the products and presents the 16-bit sum
// with a sticky overflow flag over an output valid/ready handshake.
//
// Build option:
//   FIXED_DOT_ACC_SATURATE_EN : when defined, any overflow pins the sum at
//                               16'hFFFF for the rest of the dot product;
//                               otherwise the sum wraps modulo 2^16.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : operand pair valid
//   in_ready  : block can accept an operand pair
//   in_a      : multiplicand, unsigned 8.8
//   in_b      : multiplier, unsigned 8.8
//   out_valid : result valid
//   out_ready : consumer accepts the result
//   out_sum   : accumulated sum, unsigned 8.8
//   out_ovf   : sticky overflow for this dot product
module fixed_dot_acc
    import fixed_pkg::*;
#(
    parameter int unsigned LEN   = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FIXED_W-1:0] in_a,
    input  logic [FIXED_W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIXED_W-1:0] out_sum,
    output logic               out_ovf
);

    dot_state_e         state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   cnt_q;

    // Multiply stage register
    logic               stg_valid_q;
    logic [FIXED_W-1:0] stg_prod_q;
    logic               stg_ovf_q;

    // Accumulator
    logic [FIXED_W-1:0] acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [FIXED_W:0]   sum;

    logic               accept;
    logic               last_term;
    logic [FIXED_W-1:0] mul_prod;
    logic               mul_ovf;

    fixed_mul_trunc u_mul (
        .a    (in_a),
        .b    (in_b),
        .prod (mul_prod),
        .ovf  (mul_ovf)
    );

    assign accept    = in_valid && in_ready_q;
    assign last_term = (cnt_q == CNT_W'(LEN - 1));

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, stg_prod_q};
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (stg_valid_q) begin
            ovf_d = ovf_q | sum[FIXED_W] | stg_ovf_q;
`ifdef FIXED_DOT_ACC_SATURATE_EN
            // Once any overflow has occurred the sum is pinned at the ceiling.
            acc_d = ovf_d ? FIXED_MAX : sum[FIXED_W-1:0];
`else
            acc_d = sum[FIXED_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            stg_valid_q <= 1'b0;
            stg_prod_q  <= '0;
            stg_ovf_q   <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            stg_valid_q <= accept;
            if (accept) begin
                stg_prod_q <= mul_prod;
                stg_ovf_q  <= mul_ovf;
            end

            unique case (state_q)
                ACC: begin
                    acc_q       <= acc_d;
                    ovf_q       <= ovf_d;
                    out_valid_q <= 1'b0;
                    // Also raises in_ready on the first cycle after reset release.
                    in_ready_q  <= !(accept && last_term);
                    if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_term) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Final product is folded in here; the result is then complete.
                    acc_q       <= acc_d;
                    ovf_q       <= ovf_d;
                    state_q     <= OUT;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ACC;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fixed_dot_acc.sv
// Self-checking bench for fixed_dot_acc: a LEN=4 instance and a LEN=1 instance,
// directed table vectors, hand-written corner sequences and random dot products
// checked against an arithmetic reference model.
module tb_fixed_dot_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4;
    logic [15:0] in_a4, in_b4, out_sum4;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
    logic [15:0] in_a1, in_b1, out_sum1;

    fixed_dot_acc #(.LEN(4), .CNT_W(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a4),
        .in_b      (in_b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_sum   (out_sum4),
        .out_ovf   (out_ovf4)
    );

    fixed_dot_acc #(.LEN(1), .CNT_W(2)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_ovf   (out_ovf1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, truncation by division, overflow by range.
    function automatic logic [16:0] ref_dot(input int n, input logic [3:0][15:0] a,
                                            input logic [3:0][15:0] b);
        longint unsigned s = 0;
        longint unsigned raw;
        bit o = 0;
        for (int i = 0; i < n; i++) begin
            raw = 64'(a[i]) * 64'(b[i]);
            if (raw >= 64'h0100_0000) o = 1;
            s += (raw / 256) % 65536;
            if (s >= 65536) begin
                o = 1;
                s -= 65536;
            end
        end
`ifdef FIXED_DOT_ACC_SATURATE_EN
        if (o) s = 65535;
`endif
        return {o, 16'(s)};
    endfunction

    task automatic send4(input logic [15:0] a, input logic [15:0] b);
        int t = 0;
        in_valid4 = 1'b1;
        in_a4     = a;
        in_b4     = b;
        while (!in_ready4 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready4) check("send4_ready_timeout", {31'd0, in_ready4}, 32'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic pop4(input string name);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check({name, "/pop_valid"}, {31'd0, out_valid4}, 32'd0);
        check({name, "/pop_ready"}, {31'd0, in_ready4}, 32'd1);
        check({name, "/pop_clear"}, {16'd0, out_sum4}, 32'd0);
    endtask

    task automatic run4(input string name, input bit gap, input logic [3:0][15:0] a,
                        input logic [3:0][15:0] b, input logic [15:0] esum,
                        input logic eovf, input bit release_out);
        for (int i = 0; i < 4; i++) begin
            send4(a[i], b[i]);
            if (gap && i < 3) begin
                @(posedge clk); #1;
            end
        end
        check({name, "/lat1_valid"}, {31'd0, out_valid4}, 32'd0);
        check({name, "/lat1_ready"}, {31'd0, in_ready4}, 32'd0);
        @(posedge clk); #1;
        check({name, "/lat2_valid"}, {31'd0, out_valid4}, 32'd1);
        check({name, "/sum"}, {16'd0, out_sum4}, {16'd0, esum});
        check({name, "/ovf"}, {31'd0, out_ovf4}, {31'd0, eovf});
        if (release_out) pop4(name);
    endtask

    task automatic run1(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] esum, input logic eovf);
        int t = 0;
        in_valid1 = 1'b1;
        in_a1     = a;
        in_b1     = b;
        while (!in_ready1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready1) check({name, "/ready_timeout"}, {31'd0, in_ready1}, 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check({name, "/lat1_valid"}, {31'd0, out_valid1}, 32'd0);
        @(posedge clk); #1;
        check({name, "/lat2_valid"}, {31'd0, out_valid1}, 32'd1);
        check({name, "/sum"}, {16'd0, out_sum1}, {16'd0, esum});
        check({name, "/ovf"}, {31'd0, out_ovf1}, {31'd0, eovf});
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check({name, "/pop_valid"}, {31'd0, out_valid1}, 32'd0);
    endtask

    typedef struct {
        string            name;
        bit               gap;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [15:0]      sum;
        logic             ovf;
    } vec_t;

    vec_t tbl[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] ra, rb;
        logic [16:0]      exp;
        logic [15:0]      held;
        bit               g;

`ifdef FIXED_DOT_ACC_SATURATE_EN
        localparam logic [15:0] AccOvfSum = 16'hFFFF;
        localparam logic [15:0] PrdOvfSum = 16'hFFFF;
`else
        localparam logic [15:0] AccOvfSum = 16'hC000;
        localparam logic [15:0] PrdOvfSum = 16'h0000;
`endif
        tbl[0] = '{"basic", 1'b0, {4{16'h0200}}, {4{16'h0180}}, 16'h0C00, 1'b0};
        tbl[1] = '{"acc_ovf", 1'b0, {4{16'h7000}}, {4{16'h0100}}, AccOvfSum, 1'b1};
        tbl[2] = '{"gapped", 1'b1, {4{16'h0100}}, {4{16'h0100}}, 16'h0400, 1'b0};

        rst_n = 1'b0;
        in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/in_ready", {31'd0, in_ready4}, 32'd0);
        check("reset/out_valid", {31'd0, out_valid4}, 32'd0);
        check("reset/out_sum", {16'd0, out_sum4}, 32'd0);
        check("reset/out_ovf", {31'd0, out_ovf4}, 32'd0);
        check("reset/in_ready1", {31'd0, in_ready1}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release/in_ready", {31'd0, in_ready4}, 32'd1);
        check("release/in_ready1", {31'd0, in_ready1}, 32'd1);

        foreach (tbl[i]) begin
            run4(tbl[i].name, tbl[i].gap, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].ovf, 1'b1);
        end

        // LEN=1: product overflow and fraction truncation
        run1("len1_prod_ovf", 16'h8000, 16'h0200, PrdOvfSum, 1'b1);
        run1("len1_trunc", 16'h0001, 16'h0001, 16'h0000, 1'b0);

        // Backpressure: result held, input ignored
        run4("bp", 1'b0, {4{16'h0200}}, {4{16'h0180}}, 16'h0C00, 1'b0, 1'b0);
        held = out_sum4;
        for (int c = 0; c < 5; c++) begin
            in_valid4 = 1'b1;
            in_a4     = 16'($urandom);
            in_b4     = 16'($urandom);
            @(posedge clk); #1;
            check("bp/out_valid", {31'd0, out_valid4}, 32'd1);
            check("bp/out_sum", {16'd0, out_sum4}, 32'h0C00);
            check("bp/in_ready", {31'd0, in_ready4}, 32'd0);
        end
        in_valid4 = 1'b0;
        check("bp/held_stable", {16'd0, out_sum4}, {16'd0, held});
        pop4("bp");
        run4("bp_next", 1'b0, {4{16'h0100}}, {4{16'h0100}}, 16'h0400, 1'b0, 1'b1);

        // Reset mid-stream discards partial terms
        send4(16'h0300, 16'h0100);
        send4(16'h0300, 16'h0100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst/in_ready", {31'd0, in_ready4}, 32'd0);
        check("midrst/out_sum", {16'd0, out_sum4}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst/release", {31'd0, in_ready4}, 32'd1);
        run4("midrst", 1'b0, {4{16'h0100}}, {4{16'h0100}}, 16'h0400, 1'b0, 1'b1);

        // Random dot products against the reference model
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                    : 16'($urandom_range(0, 16'h0800));
                rb[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                    : 16'($urandom_range(0, 16'h0800));
            end
            g   = 1'($urandom_range(0, 1));
            exp = ref_dot(4, ra, rb);
            run4($sformatf("rand4_%0d", r), g, ra, rb, exp[15:0], exp[16], 1'b1);
        end
        for (int r = 0; r < 8; r++) begin
            ra[0] = 16'($urandom);
            rb[0] = 16'($urandom_range(0, 16'h0300));
            exp   = ref_dot(1, ra, rb);
            run1($sformatf("rand1_%0d", r), ra[0], rb[0], exp[15:0], exp[16]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
